// File: rtl/pd_pkg.sv
// Shared defaults, fill-state encoding and the saturating-increment helper
// for the sequence pattern detector.
package pd_pkg;

   localparam int          DEF_DIGIT_W  = 4;
   localparam int          DEF_PAT_LEN  = 4;
   localparam int          DEF_NUM_PAT  = 2;
   localparam int          DEF_CNT_W    = 8;
   // p0 = 0,5,3,1 and p1 = 0,6,1,9, oldest digit in the low nibble
   localparam logic [31:0] DEF_PAT_INIT = 32'h9160_1350;

   // History fill level: nothing, partial, or a complete comparison window
   typedef enum logic [1:0] {
      FILL_EMPTY   = 2'd0,
      FILL_FILLING = 2'd1,
      FILL_FULL    = 2'd2
   } fill_state_t;

   // Increment that sticks at max_val instead of wrapping
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
      return (val >= max_val) ? max_val : val + 32'd1;
   endfunction

endpackage

// File: rtl/pd_match_counter.sv
// Saturating per-pattern match counter. clr takes priority over inc.
module pd_match_counter
   import pd_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: flush, saturating increment, or hold
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/seq_pattern_detector.sv
// Multi-pattern detector on a digit stream: the last PAT_LEN accepted digits
// are compared against NUM_PAT programmable patterns, overlapping matches
// included. Optional feature macro: PD_WILDCARD_EN (per-position care bits).
//
// Handshake: there is no back-pressure. A digit is consumed in every cycle
// where enable=1 and sync_clr=0; match/match_cnt report it one cycle later.
module seq_pattern_detector
   import pd_pkg::*;
#(
   parameter int DIGIT_W = DEF_DIGIT_W,
   parameter int PAT_LEN = DEF_PAT_LEN,
   parameter int NUM_PAT = DEF_NUM_PAT,
   parameter int CNT_W   = DEF_CNT_W,
   parameter logic [NUM_PAT*PAT_LEN*DIGIT_W-1:0] PAT_INIT = DEF_PAT_INIT,
   localparam int SEL_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1,
   localparam int POS_W  = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic [DIGIT_W-1:0]       din,
   input  logic                     sync_clr,
   input  logic                     cfg_we,
   input  logic [SEL_W-1:0]         cfg_sel,
   input  logic [POS_W-1:0]         cfg_pos,
   input  logic [DIGIT_W-1:0]       cfg_digit,
`ifdef PD_WILDCARD_EN
   input  logic                     cfg_care,
`endif
   output logic [NUM_PAT-1:0]       match,
   output logic                     any_match,
   output logic [NUM_PAT*CNT_W-1:0] match_cnt,
   output fill_state_t              fill_state
);

   localparam int                FILL_W   = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);

   // Index 0 is the oldest digit, PAT_LEN-1 the newest
   logic [PAT_LEN-1:0][DIGIT_W-1:0]              hist_q, hist_d, win;
   logic [NUM_PAT-1:0][PAT_LEN-1:0][DIGIT_W-1:0] pat_q, pat_d;
`ifdef PD_WILDCARD_EN
   logic [NUM_PAT-1:0][PAT_LEN-1:0]              care_q, care_d;
`endif
   logic [FILL_W-1:0]  fill_q, fill_d;
   fill_state_t        state_q, state_d;
   logic [NUM_PAT-1:0] match_q, match_d;
   logic               accept;
   logic               cfg_hit;

   assign accept  = enable & ~sync_clr;
   assign cfg_hit = cfg_we && (int'(cfg_sel) < NUM_PAT) && (int'(cfg_pos) < PAT_LEN);

   // Fill FSM: counts accepted digits up to a full window; sync_clr empties it
   always_comb begin
      state_d = state_q;
      fill_d  = fill_q;
      if (sync_clr) begin
         fill_d  = '0;
         state_d = FILL_EMPTY;
      end else if (accept && (fill_q != FILL_MAX)) begin
         fill_d  = fill_q + 1'b1;
         state_d = (fill_q + 1'b1 == FILL_MAX) ? FILL_FULL : FILL_FILLING;
      end
   end

   // History shift and comparison against the pre-write pattern values
   always_comb begin
      for (int k = 0; k < PAT_LEN - 1; k++) win[k] = hist_q[k+1];
      win[PAT_LEN-1] = din;
      hist_d  = hist_q;
      match_d = '0;
      if (sync_clr) begin
         hist_d = '0;
      end else if (accept) begin
         hist_d = win;
         if (fill_d == FILL_MAX) begin
            for (int p = 0; p < NUM_PAT; p++) begin
               match_d[p] = 1'b1;
               for (int k = 0; k < PAT_LEN; k++) begin
`ifdef PD_WILDCARD_EN
                  if (care_q[p][k] && (win[k] != pat_q[p][k])) match_d[p] = 1'b0;
`else
                  if (win[k] != pat_q[p][k]) match_d[p] = 1'b0;
`endif
               end
            end
         end
      end
   end

   // Pattern (and care) configuration writes; out-of-range indices are dropped
   always_comb begin
      pat_d = pat_q;
`ifdef PD_WILDCARD_EN
      care_d = care_q;
`endif
      if (cfg_hit) begin
         pat_d[cfg_sel][cfg_pos] = cfg_digit;
`ifdef PD_WILDCARD_EN
         care_d[cfg_sel][cfg_pos] = cfg_care;
`endif
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist_q  <= '0;
         fill_q  <= '0;
         state_q <= FILL_EMPTY;
         match_q <= '0;
         pat_q   <= PAT_INIT;
`ifdef PD_WILDCARD_EN
         care_q  <= '1;
`endif
      end else begin
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         state_q <= state_d;
         match_q <= match_d;
         pat_q   <= pat_d;
`ifdef PD_WILDCARD_EN
         care_q  <= care_d;
`endif
      end
   end

   // Counters step on the same edge that raises the match pulse
   for (genvar p = 0; p < NUM_PAT; p++) begin : g_cnt
      pd_match_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk     (clk),
         .reset_n (reset_n),
         .inc     (match_d[p]),
         .clr     (sync_clr),
         .cnt     (match_cnt[p*CNT_W +: CNT_W])
      );
   end

   assign match      = match_q;
   assign any_match  = |match_q;
   assign fill_state = state_q;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: a default instance and a CNT_W=2 instance
// share all inputs. A reference model predicts each cycle's outputs into a
// queue which is drained and compared after every clock edge.
module tb_seq_pattern_detector;
   import pd_pkg::*;

   localparam int EW = 24;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n;
   logic       enable;
   logic [3:0] din;
   logic       sync_clr;
   logic       cfg_we;
   logic [0:0] cfg_sel;
   logic [1:0] cfg_pos;
   logic [3:0] cfg_digit;
   logic       cfg_care;

   logic [1:0]  match_a, match_b;
   logic        any_a, any_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;
   fill_state_t fs_a, fs_b;

   seq_pattern_detector u_dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .din(din), .sync_clr(sync_clr),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_pos(cfg_pos), .cfg_digit(cfg_digit),
`ifdef PD_WILDCARD_EN
      .cfg_care(cfg_care),
`endif
      .match(match_a), .any_match(any_a), .match_cnt(cnt_a), .fill_state(fs_a)
   );

   seq_pattern_detector #(.CNT_W(2)) u_dut_c2 (
      .clk(clk), .reset_n(reset_n), .enable(enable), .din(din), .sync_clr(sync_clr),
      .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_pos(cfg_pos), .cfg_digit(cfg_digit),
`ifdef PD_WILDCARD_EN
      .cfg_care(cfg_care),
`endif
      .match(match_b), .any_match(any_b), .match_cnt(cnt_b), .fill_state(fs_b)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [EW-1:0] exp_q[$];

   int m_hist[4];
   int m_fill;
   int m_pat[2][4];
   int m_care[2][4];
   int m_cnt[2];
   int m_cnt2[2];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 4; k++) m_hist[k] = 0;
      m_fill = 0;
      m_pat[0] = '{0, 5, 3, 1};
      m_pat[1] = '{0, 6, 1, 9};
      for (int p = 0; p < 2; p++) begin
         m_cnt[p]  = 0;
         m_cnt2[p] = 0;
         for (int k = 0; k < 4; k++) m_care[p][k] = 1;
      end
   endtask

   // ---------------- driver ----------------
   task automatic cyc(input logic en, input logic [3:0] d, input logic clr, input logic we,
                      input logic sel, input logic [1:0] pos, input logic [3:0] dig,
                      input logic care);
      int mt[2];
      int st;
      logic [EW-1:0] e;
      enable = en; din = d; sync_clr = clr;
      cfg_we = we; cfg_sel = sel; cfg_pos = pos; cfg_digit = dig; cfg_care = care;
      mt[0] = 0; mt[1] = 0;
      if (clr) begin
         for (int k = 0; k < 4; k++) m_hist[k] = 0;
         m_fill = 0;
         m_cnt = '{0, 0};
         m_cnt2 = '{0, 0};
      end else if (en) begin
         m_hist[0] = m_hist[1]; m_hist[1] = m_hist[2]; m_hist[2] = m_hist[3];
         m_hist[3] = int'(d);
         if (m_fill < 4) m_fill++;
         if (m_fill == 4) begin
            for (int p = 0; p < 2; p++) begin
               mt[p] = 1;
               for (int k = 0; k < 4; k++)
                  if (m_care[p][k] != 0 && m_hist[k] != m_pat[p][k]) mt[p] = 0;
               if (mt[p] != 0) begin
                  if (m_cnt[p] < 255) m_cnt[p]++;
                  if (m_cnt2[p] < 3) m_cnt2[p]++;
               end
            end
         end
      end
      if (we) begin
         m_pat[sel][pos] = int'(dig);
`ifdef PD_WILDCARD_EN
         m_care[sel][pos] = int'(care);
`endif
      end
      st = (m_fill == 0) ? 0 : (m_fill == 4) ? 2 : 1;
      e = {mt[1][0], mt[0][0], m_cnt[0][7:0], m_cnt[1][7:0], m_cnt2[0][1:0], m_cnt2[1][1:0], st[1:0]};
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check_eq("queue_empty", 32'd1, 32'd0);
      end else begin
         e = exp_q.pop_front();
         check_eq("match",       32'(match_a),      32'(e[23:22]));
         check_eq("any_match",   32'(any_a),        32'(|e[23:22]));
         check_eq("cnt0",        32'(cnt_a[7:0]),   32'(e[21:14]));
         check_eq("cnt1",        32'(cnt_a[15:8]),  32'(e[13:6]));
         check_eq("cnt2w_0",     32'(cnt_b[1:0]),   32'(e[5:4]));
         check_eq("cnt2w_1",     32'(cnt_b[3:2]),   32'(e[3:2]));
         check_eq("fill_state",  32'(fs_a),         32'(e[1:0]));
      end
   endtask

   task automatic feed(input logic [3:0] d);
      cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
   endtask

   task automatic stall();
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
   endtask

   task automatic feed4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d);
      feed(a); feed(b); feed(c); feed(d);
   endtask

   task automatic do_reset();
      enable = 1'b0; din = '0; sync_clr = 1'b0; cfg_we = 1'b0;
      cfg_sel = '0; cfg_pos = '0; cfg_digit = '0; cfg_care = 1'b1;
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rst_match",     32'(match_a), 32'd0);
      check_eq("rst_any",       32'(any_a),   32'd0);
      check_eq("rst_cnt",       32'(cnt_a),   32'd0);
      check_eq("rst_cnt2w",     32'(cnt_b),   32'd0);
      check_eq("rst_fill",      32'(fs_a),    32'(FILL_EMPTY));
      reset_n = 1'b1;
      model_reset();
      exp_q.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] pool[6];
      pool = '{4'd0, 4'd5, 4'd3, 4'd1, 4'd6, 4'd9};

      // default pattern 0 on a fresh window
      do_reset();
      feed4(0, 5, 3, 1);
      stall();

      // back-to-back overlapping pattern 1
      feed4(0, 6, 1, 9);
      feed4(0, 6, 1, 9);
      stall();

      // stalls between digits never pulse and never break the window
      do_reset();
      feed(0); stall(); stall(); stall(); feed(5); feed(3); stall(); feed(1); stall();

      // partial window, then sync_clr drops the completing digit
      do_reset();
      feed(5); feed(3); feed(1);
      feed(0); feed(5); feed(3);
      cyc(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1);
      feed(1); stall();

      // reprogram pattern 1, same-cycle write uses old value
      do_reset();
      cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 2'd3, 4'd7, 1'b1);
      feed4(0, 6, 1, 7);
      feed4(0, 6, 1, 9);
      feed(0); feed(6); feed(1);
      cyc(1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 2'd3, 4'd9, 1'b1);
      feed4(0, 6, 1, 9);
      cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 2'd3, 4'd7, 1'b1);
      do_reset();
      feed4(0, 6, 1, 9);

      // saturation of the 2-bit counter instance
      do_reset();
      for (int i = 0; i < 5; i++) feed4(0, 5, 3, 1);
      stall();

`ifdef PD_WILDCARD_EN
      do_reset();
      cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 2'd1, 4'd5, 1'b0);
      feed4(0, 8, 3, 1);
      stall();
`endif

      // random mix of digits, stalls, flushes and pattern writes
      do_reset();
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom_range(0, 3) != 0),
             pool[$urandom_range(0, 5)],
             1'($urandom_range(0, 60) == 0),
             1'($urandom_range(0, 30) == 0),
             1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)),
             pool[$urandom_range(0, 5)],
             1'($urandom_range(0, 3) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // hard time limit so the run always ends
   initial begin
      #2_000_000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
